// File: rtl/mem_arbiter.sv
// Shares one single-port memory between an instruction-fetch port and a data port.
// On contention the grant alternates; every access runs a fixed LATENCY countdown.
module mem_arbiter #(
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic        i_ack,
    output logic [15:0] i_rdata,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_ack,
    output logic [15:0] d_rdata,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY);

    state_t      state, state_nx;
    owner_t      owner, last_owner, grant;
    logic [3:0]  count;
    logic        acc_wr;
    logic [15:0] acc_addr, acc_wdata;
    logic [15:0] i_rdata_q, d_rdata_q;

    // With both sides asking, the side that did not win last time goes first.
    always_comb begin
        if (i_req && d_req) grant = (last_owner == OWN_I) ? OWN_D : OWN_I;
        else if (d_req)     grant = OWN_D;
        else                grant = OWN_I;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        // NOTE: default first so no path leaves state_nx unassigned, which would infer a latch.
        state_nx = state;
        case (state)
            IDLE:    if (i_req || d_req) state_nx = BUSY;
            BUSY:    if (count == 4'd1)  state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: the read-data holders are ordinary flops, not a RAM, so they take the reset too.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner      <= OWN_I;
            last_owner <= OWN_I;
            count      <= '0;
            acc_wr     <= 1'b0;
            acc_addr   <= '0;
            acc_wdata  <= '0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            case (state)
                IDLE: if (i_req || d_req) begin
                    owner     <= grant;
                    acc_addr  <= (grant == OWN_D) ? d_addr : i_addr;
                    acc_wr    <= (grant == OWN_D) && d_wr;
                    acc_wdata <= (grant == OWN_D) ? d_wdata : '0;
                    count     <= CNT_INIT;
                end
                BUSY: begin
                    count <= count - 4'd1;
                    // Stores never touch the read-data holders.
                    if (count == 4'd1 && !acc_wr) begin
                        if (owner == OWN_D) d_rdata_q <= mem_rdata;
                        else                i_rdata_q <= mem_rdata;
                    end
                end
                RESP:    last_owner <= owner;
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        i_ack     = 1'b0;
        d_ack     = 1'b0;
        case (state)
            BUSY: begin
                mem_en    = (count == CNT_INIT);
                mem_wr    = acc_wr;
                mem_addr  = acc_addr;
                mem_wdata = acc_wdata;
            end
            RESP: begin
                i_ack = (owner == OWN_I);
                d_ack = (owner == OWN_D);
            end
            default: ;
        endcase
    end

    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a transaction-level reference model predicts every
// cycle's outputs from grant time and LATENCY; directed scenarios check the key timings.
module tb_mem_arbiter;
    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_wr;
    logic [15:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic        i_ack, d_ack, mem_en, mem_wr;
    logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata;

    // Second instance built with LATENCY=1, driven by its own small directed test.
    logic        l1_i_req = 1'b0, l1_d_req = 1'b0, l1_d_wr = 1'b0;
    logic [15:0] l1_i_addr = '0, l1_d_addr = '0, l1_d_wdata = '0, l1_mem_rdata;
    logic        l1_i_ack, l1_d_ack, l1_mem_en, l1_mem_wr;
    logic [15:0] l1_i_rdata, l1_d_rdata, l1_mem_addr, l1_mem_wdata;

    always #5 clk = ~clk;

    mem_arbiter #(.LATENCY(LAT)) u_dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst(rst),
        .i_req(l1_i_req), .i_addr(l1_i_addr), .i_ack(l1_i_ack), .i_rdata(l1_i_rdata),
        .d_req(l1_d_req), .d_wr(l1_d_wr), .d_addr(l1_d_addr), .d_wdata(l1_d_wdata),
        .d_ack(l1_d_ack), .d_rdata(l1_d_rdata),
        .mem_en(l1_mem_en), .mem_wr(l1_mem_wr), .mem_addr(l1_mem_addr),
        .mem_wdata(l1_mem_wdata), .mem_rdata(l1_mem_rdata)
    );

    assign l1_mem_rdata = l1_mem_en ? 16'h5A5A : 16'h1111;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Environment memory seen by the DUT, and the model's own copy of the same contents.
    logic [15:0] mem_arr [0:65535];
    logic [15:0] ref_mem [0:65535];

    // Memory responder: read data is only valid in the capture cycle, junk otherwise.
    int          env_e = -100;
    logic [15:0] env_addr = '0;
    bit          env_wr = 1'b0;
    initial begin
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_en) begin
                env_e    = cyc;
                env_addr = mem_addr;
                env_wr   = mem_wr;
                if (mem_wr) mem_arr[mem_addr] = mem_wdata;
            end
            if (!env_wr && cyc == env_e + LAT - 1) mem_rdata = mem_arr[env_addr];
            else                                   mem_rdata = 16'($urandom);
        end
    end

    // Reference model: one access at a time, occupying cycles g+1..g+LAT+1 after grant cycle g.
    bit          m_busy = 1'b0, m_owner = 1'b0, m_last = 1'b0, m_wr = 1'b0;
    int          m_g = 0, m_acks = 0, n_acks_seen = 0;
    logic [15:0] m_addr = '0, m_wdata = '0, m_rdv = '0;
    logic [15:0] m_irdata = '0, m_drdata = '0;
    bit          in_mem, in_ack;

    always @(negedge clk) begin
        n_acks_seen += int'(i_ack) + int'(d_ack);
        if (rst) begin
            m_busy = 1'b0; m_last = 1'b0; m_irdata = '0; m_drdata = '0;
            check("rst_ctl", {i_ack, d_ack, mem_en, mem_wr}, 4'b0000);
            check("rst_mem_addr", mem_addr, 16'h0);
            check("rst_mem_wdata", mem_wdata, 16'h0);
            check("rst_rdata", {i_rdata, d_rdata}, 32'h0);
        end else begin
            in_mem = m_busy && cyc >= m_g + 1 && cyc <= m_g + LAT;
            in_ack = m_busy && cyc == m_g + LAT + 1;
            if (in_ack && !m_wr) begin
                if (m_owner) m_drdata = m_rdv;
                else         m_irdata = m_rdv;
            end
            check("mem_en", mem_en, m_busy && cyc == m_g + 1);
            check("mem_wr", mem_wr, in_mem && m_wr);
            check("mem_addr", mem_addr, in_mem ? m_addr : 16'h0);
            check("mem_wdata", mem_wdata, in_mem ? m_wdata : 16'h0);
            check("i_ack", i_ack, in_ack && !m_owner);
            check("d_ack", d_ack, in_ack && m_owner);
            check("i_rdata", i_rdata, m_irdata);
            check("d_rdata", d_rdata, m_drdata);
            if (in_ack) begin
                m_busy = 1'b0;
                m_last = m_owner;
                m_acks++;
            end else if (!m_busy && (i_req || d_req)) begin
                m_owner = (i_req && d_req) ? !m_last : d_req;
                m_g     = cyc;
                m_busy  = 1'b1;
                m_addr  = m_owner ? d_addr : i_addr;
                m_wr    = m_owner && d_wr;
                m_wdata = m_owner ? d_wdata : 16'h0;
                if (m_wr) ref_mem[m_addr] = m_wdata;
                else      m_rdv = ref_mem[m_addr];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    // Runs until both requests have been served (requests drop the cycle after their ack).
    task automatic serve(input int max, output int i_lat, output int d_lat, output int en_lat);
        int  c0;
        bit  ia, da;
        c0 = cyc;
        i_lat = -1; d_lat = -1; en_lat = -1;
        for (int k = 0; k < max && (i_req || d_req); k++) begin
            @(negedge clk);
            ia = i_ack; da = d_ack;
            if (mem_en && en_lat < 0) en_lat = cyc - c0;
            if (ia && i_lat < 0) i_lat = cyc - c0;
            if (da && d_lat < 0) d_lat = cyc - c0;
            tick();
            if (ia) i_req = 1'b0;
            if (da) d_req = 1'b0;
        end
    endtask

    int          il, dl, el, n_ord;
    logic [3:0]  order;
    int          i_issued, d_issued, i_wait, d_wait;
    bit          ia, da, stall;

    initial begin
        rst = 1'b1;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0;
        for (int i = 0; i < 65536; i++) begin
            logic [15:0] v;
            v = 16'($urandom);
            mem_arr[i] = v;
            ref_mem[i] = v;
        end
        mem_arr[16'h0010] = 16'hA123; ref_mem[16'h0010] = 16'hA123;
        mem_arr[16'h0020] = 16'h1234; ref_mem[16'h0020] = 16'h1234;
        repeat (2) tick();
        check("reset_acks", {i_ack, d_ack}, 2'b00);
        rst = 1'b0;
        tick();

        // Contention straight after reset: D first, then I.
        i_req = 1'b1; i_addr = 16'h0010;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0020; d_wdata = 16'h7777;
        serve(40, il, dl, el);
        check("contend_d_ack_cycle", dl, 5);
        check("contend_i_ack_cycle", il, 11);
        check("contend_d_rdata", d_rdata, 16'h1234);

        // Single fetch.
        tick();
        i_req = 1'b1; i_addr = 16'h0010;
        serve(20, il, dl, el);
        check("fetch_mem_en_cycle", el, 1);
        check("fetch_ack_cycle", il, 5);
        check("fetch_rdata", i_rdata, 16'hA123);

        // Store leaves d_rdata alone.
        tick();
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0200; d_wdata = 16'hBEEF;
        serve(20, il, dl, el);
        check("store_ack_cycle", dl, 5);
        check("store_d_rdata", d_rdata, 16'h1234);
        check("store_mem_written", mem_arr[16'h0200], 16'hBEEF);
        d_wr = 1'b0;

        // Continuous contention for four accesses.
        do_reset();
        order = '0; n_ord = 0;
        i_req = 1'b1; i_addr = 16'h0030; i_issued = 1;
        d_req = 1'b1; d_addr = 16'h0040; d_issued = 1;
        for (int k = 0; k < 80 && n_ord < 4; k++) begin
            @(negedge clk);
            ia = i_ack; da = d_ack;
            if (ia || da) begin
                order[n_ord] = da;
                n_ord++;
            end
            tick();
            if (ia) i_req = 1'b0;
            else if (!i_req && i_issued < 2) begin i_req = 1'b1; i_addr = 16'h0031; i_issued++; end
            if (da) d_req = 1'b0;
            else if (!d_req && d_issued < 2) begin d_req = 1'b1; d_addr = 16'h0041; d_issued++; end
        end
        check("alt_count", n_ord, 4);
        check("alt_order", order, 4'b0101);

        // Reset in cycle 3 of a load aborts it; the held request is served afresh.
        tick();
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0300;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        check("rst_async_out", {mem_en, mem_wr, mem_addr, mem_wdata}, 34'h0);
        tick();
        rst = 1'b0;
        serve(20, il, dl, el);
        check("rst_reserve_ack", dl, 5);
        check("rst_reserve_rdata", d_rdata, ref_mem[16'h0300]);

        // Randomized traffic from both sides.
        stall = 1'b0; i_wait = 0; d_wait = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            ia = i_ack; da = d_ack;
            tick();
            if (ia) i_req = 1'b0;
            else if (!i_req && $urandom_range(0, 3) == 0) begin
                i_req = 1'b1; i_addr = 16'($urandom_range(0, 31));
            end
            if (da) d_req = 1'b0;
            else if (!d_req && $urandom_range(0, 3) == 0) begin
                d_req = 1'b1; d_wr = 1'($urandom_range(0, 1));
                d_addr = 16'($urandom_range(0, 31)); d_wdata = 16'($urandom);
            end
            i_wait = i_req ? i_wait + 1 : 0;
            d_wait = d_req ? d_wait + 1 : 0;
            if (i_wait > 30 || d_wait > 30) stall = 1'b1;
        end
        serve(60, il, dl, el);
        check("rand_no_stall", stall, 1'b0);
        check("rand_drained", {i_req, d_req}, 2'b00);
        check("ack_count", n_acks_seen, m_acks);

        // LATENCY=1 instance: single load.
        begin
            int c0, men, ack;
            logic [15:0] rd;
            c0 = cyc; men = -1; ack = -1; rd = '0;
            l1_d_req = 1'b1; l1_d_addr = 16'h0040;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                if (l1_mem_en && men < 0) men = cyc - c0;
                if (l1_d_ack && ack < 0) begin ack = cyc - c0; rd = l1_d_rdata; end
                tick();
                if (ack >= 0) l1_d_req = 1'b0;
            end
            check("lat1_mem_en_cycle", men, 1);
            check("lat1_ack_cycle", ack, 2);
            check("lat1_rdata", rd, 16'h5A5A);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
